// File: rtl/arb_burst_mux.sv
// arb_burst_mux: latches the client named by a one-hot arbiter grant and
// streams a fixed-length burst of that client's payload onto one shared
// valid/ready channel. Also generates per-client pop/done pulses, flags
// malformed grants and aborts bursts that stall too long.
module arb_burst_mux #(
   parameter int N         = 4,
   parameter int DW        = 8,
   parameter int BEATS     = 4,
   parameter int STALL_MAX = 16,
   localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    grant,
   input  logic [N*DW-1:0] data_in,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [IW-1:0]   out_id,
   output logic            out_last,
   output logic [N-1:0]    client_pop,
   output logic [N-1:0]    done,
   output logic            busy,
   output logic            err_grant,
   output logic            timeout
);

   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SW = $clog2(STALL_MAX + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [IW-1:0] id_q, id_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic [SW-1:0] stall_cnt_q, stall_cnt_d;
   logic [N-1:0]  done_q, done_d;
   logic          err_grant_q, err_grant_d;
   logic          timeout_q, timeout_d;

   logic          grant_any;
   logic          grant_onehot;
   logic [IW-1:0] grant_idx;
   logic          accept;
   logic          last_beat;
   logic          stall_limit;

   // A grant is one-hot when it is non-zero and clearing its lowest set bit leaves nothing.
   assign grant_any    = |grant;
   assign grant_onehot = grant_any & ~|(grant & (grant - N'(1)));

   // Encode the index of the granted client; only meaningful when the grant is one-hot.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) grant_idx = IW'(i);
      end
   end

   assign out_valid   = (state_q == S_BURST);
   assign busy        = out_valid;
   assign accept      = out_valid & out_ready;
   assign last_beat   = (beat_cnt_q == BW'(BEATS - 1));
   assign out_last    = out_valid & last_beat;
   assign stall_limit = (stall_cnt_q == SW'(STALL_MAX - 1));
   assign out_id      = id_q;
   // Payload is not registered: the owner's current beat goes straight through.
   assign out_data    = out_valid ? data_in[id_q*DW +: DW] : '0;
   assign done        = done_q;
   assign err_grant   = err_grant_q;
   assign timeout     = timeout_q;

   // Per-client pop strobe: only the burst owner sees its accepted beats.
   for (genvar gi = 0; gi < N; gi++) begin : g_pop
      assign client_pop[gi] = accept & (id_q == IW'(gi));
   end

   // Next-state logic: capture in IDLE, count beats and stalls in BURST.
   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
      done_d      = '0;
      err_grant_d = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_onehot) begin
               id_d        = grant_idx;
               beat_cnt_d  = '0;
               stall_cnt_d = '0;
               state_d     = S_BURST;
            end else if (grant_any) begin
               err_grant_d = 1'b1;
            end
         end
         default: begin
            // An accept on the stall-limit cycle wins over the abort.
            if (accept) begin
               stall_cnt_d = '0;
               if (last_beat) begin
                  beat_cnt_d = '0;
                  done_d     = client_pop;
                  state_d    = S_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BW'(1);
               end
            end else if (stall_limit) begin
               beat_cnt_d  = '0;
               stall_cnt_d = '0;
               timeout_d   = 1'b1;
               state_d     = S_IDLE;
            end else begin
               stall_cnt_d = stall_cnt_q + SW'(1);
            end
         end
      endcase
   end

   // State and pulse registers; reset drops any burst in progress without a done or timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         id_q        <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
         done_q      <= '0;
         err_grant_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         done_q      <= done_d;
         err_grant_q <= err_grant_d;
         timeout_q   <= timeout_d;
      end
   end

endmodule

// File: tb/tb_arb_burst_mux.sv
// tb_arb_burst_mux: directed scenarios plus a randomized run checked against
// a transaction-level reference model of the burst multiplexer.
module tb_arb_burst_mux;

   localparam int N         = 4;
   localparam int DW        = 8;
   localparam int BEATS     = 4;
   localparam int STALL_MAX = 16;

   logic            clk;
   logic            reset;
   logic [N-1:0]    grant;
   logic [N*DW-1:0] data_in;
   logic            out_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_id;
   logic            out_last;
   logic [N-1:0]    client_pop;
   logic [N-1:0]    done;
   logic            busy;
   logic            err_grant;
   logic            timeout;

   int ctr [N];
   int n_checks;
   int n_fail;

   arb_burst_mux #(.N(N), .DW(DW), .BEATS(BEATS), .STALL_MAX(STALL_MAX)) dut (
      .clk(clk), .reset(reset), .grant(grant), .data_in(data_in),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_id(out_id), .out_last(out_last), .client_pop(client_pop),
      .done(done), .busy(busy), .err_grant(err_grant), .timeout(timeout)
   );

   initial clk = 1'b0;
   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Client k presents payload (0x60 + 0x20*k + beats popped so far).
   always_comb begin
      data_in = '0;
      for (int i = 0; i < N; i++) data_in[i*DW +: DW] = DW'(96 + 32*i + ctr[i]);
   end

   function automatic logic [DW-1:0] beat_val(int c, int k);
      return DW'(96 + 32*c + k);
   endfunction

   task automatic clear_clients();
      for (int i = 0; i < N; i++) ctr[i] = 0;
   endtask

   // Finish the current cycle: note the pops, cross the edge, let clients advance.
   task automatic advance();
      logic [N-1:0] p;
      if (clk) @(negedge clk);
      p = client_pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (p[i]) ctr[i] = ctr[i] + 1;
   endtask

   // Let any burst run out with ready high, bounded, then flush trailing pulses.
   task automatic drain();
      grant = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         advance();
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drain: busy=%b required 0 within 40 cycles", busy);
      end
      advance();
      advance();
   endtask

   task automatic test_reset();
      grant = 4'b0001;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_last, busy, client_pop, done, err_grant, timeout} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: valid=%b last=%b busy=%b pop=%b done=%b err=%b to=%b required all 0",
                  out_valid, out_last, busy, client_pop, done, err_grant, timeout);
      end
      n_checks++;
      if ({out_id, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: id=%0d data=%h required 0 00", out_id, out_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      grant = '0;
      advance();
   endtask

   task automatic test_single_burst();
      clear_clients();
      out_ready = 1'b1;
      grant = 4'b0100;
      advance();
      grant = '0;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, busy, out_id, out_last, client_pop} !== {1'b1, 1'b1, 2'd2, (k == BEATS-1), 4'b0100}) begin
            n_fail++;
            $display("FAIL single_ctrl beat %0d: valid=%b busy=%b id=%0d last=%b pop=%b required 1 1 2 %b 0100",
                     k, out_valid, busy, out_id, out_last, client_pop, (k == BEATS-1));
         end
         n_checks++;
         if (out_data !== beat_val(2, k)) begin
            n_fail++;
            $display("FAIL single_data beat %0d: data=%h required %h", k, out_data, beat_val(2, k));
         end
         advance();
      end
      @(negedge clk);
      n_checks++;
      if (done !== 4'b0100 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%b valid=%b required 0100 0", done, out_valid);
      end
      advance();
      @(negedge clk);
      n_checks++;
      if (done !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_done_width: done=%b required 0000", done);
      end
      advance();
   endtask

   task automatic test_backpressure();
      int beats;
      int pops;
      int cyc;
      clear_clients();
      beats = 0;
      pops = 0;
      cyc = 0;
      out_ready = 1'b0;
      grant = 4'b0100;
      advance();
      grant = '0;
      while (beats < BEATS && cyc < 40) begin
         out_ready = (cyc % 2 == 0);
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== beat_val(2, beats) || out_last !== (beats == BEATS-1)) begin
            n_fail++;
            $display("FAIL bp_beat cyc %0d: valid=%b data=%h last=%b required 1 %h %b",
                     cyc, out_valid, out_data, out_last, beat_val(2, beats), (beats == BEATS-1));
         end
         n_checks++;
         if (client_pop !== (out_ready ? 4'b0100 : 4'b0000)) begin
            n_fail++;
            $display("FAIL bp_pop cyc %0d: pop=%b required %b", cyc, client_pop, (out_ready ? 4'b0100 : 4'b0000));
         end
         if (client_pop[2]) pops++;
         if (out_ready) beats++;
         advance();
         cyc++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pops != BEATS || done !== 4'b0100 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_end: pops=%0d done=%b busy=%b required %0d 0100 0", pops, done, busy, BEATS);
      end
      advance();
   endtask

   task automatic test_timeout();
      clear_clients();
      out_ready = 1'b1;
      grant = 4'b0001;
      advance();
      grant = '0;
      @(negedge clk);
      n_checks++;
      if (client_pop !== 4'b0001 || out_data !== beat_val(0, 0)) begin
         n_fail++;
         $display("FAIL to_first: pop=%b data=%h required 0001 %h", client_pop, out_data, beat_val(0, 0));
      end
      advance();
      out_ready = 1'b0;
      for (int j = 1; j <= STALL_MAX; j++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, out_valid, timeout, client_pop, done} !== {1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000} ||
             out_data !== beat_val(0, 1)) begin
            n_fail++;
            $display("FAIL to_stall %0d: busy=%b valid=%b to=%b pop=%b done=%b data=%h required 1 1 0 0000 0000 %h",
                     j, busy, out_valid, timeout, client_pop, done, out_data, beat_val(0, 1));
         end
         advance();
      end
      @(negedge clk);
      n_checks++;
      if (timeout !== 1'b1 || busy !== 1'b0 || done !== 4'b0000) begin
         n_fail++;
         $display("FAIL to_pulse: to=%b busy=%b done=%b required 1 0 0000", timeout, busy, done);
      end
      advance();
      @(negedge clk);
      n_checks++;
      if (timeout !== 1'b0 || busy !== 1'b0 || done !== 4'b0000) begin
         n_fail++;
         $display("FAIL to_after: to=%b busy=%b done=%b required 0 0 0000", timeout, busy, done);
      end
      advance();
      out_ready = 1'b1;
   endtask

   task automatic test_bad_grant();
      clear_clients();
      out_ready = 1'b1;
      grant = 4'b0110;
      @(negedge clk);
      n_checks++;
      if (err_grant !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_pre: err=%b busy=%b required 0 0", err_grant, busy);
      end
      advance();
      grant = '0;
      @(negedge clk);
      n_checks++;
      if (err_grant !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_pulse: err=%b busy=%b valid=%b required 1 0 0", err_grant, busy, out_valid);
      end
      advance();
      @(negedge clk);
      n_checks++;
      if (err_grant !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_after: err=%b busy=%b required 0 0", err_grant, busy);
      end
      advance();
      grant = 4'b0001;
      advance();
      grant = '0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== beat_val(0, 0)) begin
         n_fail++;
         $display("FAIL bad_recover: valid=%b id=%0d data=%h required 1 0 %h", out_valid, out_id, out_data, beat_val(0, 0));
      end
      drain();
   endtask

   task automatic test_back_to_back();
      clear_clients();
      out_ready = 1'b1;
      grant = 4'b0001;
      advance();
      grant = 4'b1000;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== beat_val(0, k)) begin
            n_fail++;
            $display("FAIL b2b_first beat %0d: valid=%b id=%0d data=%h required 1 0 %h",
                     k, out_valid, out_id, out_data, beat_val(0, k));
         end
         advance();
      end
      @(negedge clk);
      n_checks++;
      if (done !== 4'b0001 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_gap: done=%b valid=%b required 0001 0", done, out_valid);
      end
      advance();
      grant = '0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== beat_val(3, 0)) begin
         n_fail++;
         $display("FAIL b2b_second: valid=%b id=%0d data=%h required 1 3 %h", out_valid, out_id, out_data, beat_val(3, 0));
      end
      drain();
   endtask

   task automatic test_reset_mid_burst();
      clear_clients();
      out_ready = 1'b1;
      grant = 4'b0010;
      advance();
      grant = '0;
      repeat (2) begin
         @(negedge clk);
         advance();
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_last, busy, client_pop, done, err_grant, timeout, out_id, out_data} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid: valid=%b last=%b busy=%b pop=%b done=%b err=%b to=%b id=%0d data=%h required all 0",
                  out_valid, out_last, busy, client_pop, done, err_grant, timeout, out_id, out_data);
      end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, done, timeout} !== '0) begin
            n_fail++;
            $display("FAIL rst_hold %0d: busy=%b done=%b to=%b required 0 0000 0", j, busy, done, timeout);
         end
         advance();
      end
      #2;
      reset = 1'b1;
      clear_clients();
      grant = 4'b0100;
      advance();
      grant = '0;
      for (int k = 0; k < BEATS; k++) begin
         @(negedge clk);
         n_checks++;
         if (client_pop !== 4'b0100 || out_id !== 2'd2 || out_data !== beat_val(2, k) || out_last !== (k == BEATS-1)) begin
            n_fail++;
            $display("FAIL rst_restart beat %0d: pop=%b id=%0d data=%h last=%b required 0100 2 %h %b",
                     k, client_pop, out_id, out_data, out_last, beat_val(2, k), (k == BEATS-1));
         end
         advance();
      end
      @(negedge clk);
      n_checks++;
      if (done !== 4'b0100 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_restart_done: done=%b to=%b required 0100 0", done, timeout);
      end
      advance();
   endtask

   // Randomized traffic against a burst-level model: who owns the channel,
   // how many beats it has sent, and how long it has been waiting.
   task automatic test_random();
      bit           m_active;
      int           m_owner;
      int           m_sent;
      int           m_stall;
      int           m_done_owner;
      bit           m_err;
      bit           m_to;
      int           m_cnt [N];
      int           pct;
      int           r;
      int           a;
      int           b;
      logic         exp_last;
      logic [N-1:0] exp_pop;
      logic [N-1:0] exp_done;
      logic [DW-1:0] exp_data;
      m_active = 0;
      m_owner = 0;
      m_sent = 0;
      m_stall = 0;
      m_done_owner = -1;
      m_err = 0;
      m_to = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = ctr[i];
      for (int cyc = 0; cyc < 600; cyc++) begin
         pct = ((cyc / 100) % 3 == 0) ? 85 : (((cyc / 100) % 3 == 1) ? 50 : 4);
         out_ready = ($urandom_range(0, 99) < pct);
         r = $urandom_range(0, 9);
         if (r < 5) grant = '0;
         else if (r < 9) grant = N'(1) << $urandom_range(0, N-1);
         else begin
            a = $urandom_range(0, N-1);
            b = (a + 1 + $urandom_range(0, N-2)) % N;
            grant = (N'(1) << a) | (N'(1) << b);
         end
         exp_last = m_active && (m_sent == BEATS-1);
         exp_pop  = (m_active && out_ready) ? (N'(1) << m_owner) : '0;
         exp_done = (m_done_owner >= 0) ? (N'(1) << m_done_owner) : '0;
         exp_data = beat_val(m_owner, m_cnt[m_owner]);
         @(negedge clk);
         n_checks++;
         if ({out_valid, busy, out_last} !== {m_active, m_active, exp_last}) begin
            n_fail++;
            $display("FAIL rnd_ctrl cyc %0d: valid=%b busy=%b last=%b required %b %b %b",
                     cyc, out_valid, busy, out_last, m_active, m_active, exp_last);
         end
         n_checks++;
         if (client_pop !== exp_pop) begin
            n_fail++;
            $display("FAIL rnd_pop cyc %0d: pop=%b required %b", cyc, client_pop, exp_pop);
         end
         n_checks++;
         if ({done, err_grant, timeout} !== {exp_done, m_err, m_to}) begin
            n_fail++;
            $display("FAIL rnd_pulse cyc %0d: done=%b err=%b to=%b required %b %b %b",
                     cyc, done, err_grant, timeout, exp_done, m_err, m_to);
         end
         if (m_active) begin
            n_checks++;
            if (out_id !== 2'(m_owner) || out_data !== exp_data) begin
               n_fail++;
               $display("FAIL rnd_data cyc %0d: id=%0d data=%h required %0d %h", cyc, out_id, out_data, m_owner, exp_data);
            end
         end
         m_done_owner = -1;
         m_err = 0;
         m_to = 0;
         if (m_active) begin
            if (out_ready) begin
               m_cnt[m_owner]++;
               m_sent++;
               m_stall = 0;
               if (m_sent == BEATS) begin
                  m_active = 0;
                  m_done_owner = m_owner;
               end
            end else begin
               m_stall++;
               if (m_stall == STALL_MAX) begin
                  m_active = 0;
                  m_to = 1;
               end
            end
         end else if ($countones(grant) == 1) begin
            for (int i = 0; i < N; i++) if (grant[i]) m_owner = i;
            m_active = 1;
            m_sent = 0;
            m_stall = 0;
         end else if ($countones(grant) > 1) begin
            m_err = 1;
         end
         advance();
      end
      drain();
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      reset = 1'b0;
      grant = '0;
      out_ready = 1'b0;
      clear_clients();
      test_reset();
      test_single_burst();
      test_backpressure();
      test_timeout();
      test_bad_grant();
      test_back_to_back();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case the design wedges the bench.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500000, required completion earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
